// File: rtl/control_unit.sv
// control_unit: Moore sequencer for the CPU datapath (fetch plus execute steps).
// Ports: Clock, Clear, IR, ConFF_Out, Stop in; Run, CONTROL, bus/load strobes out.
module control_unit (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        ConFF_Out,
  input  logic        Stop,
  output logic        Run,
  output logic [4:0]  CONTROL,
  output logic        PC_Out,
  output logic        MDR_Out,
  output logic        ZHI_Out,
  output logic        ZLO_Out,
  output logic        HI_Out,
  output logic        LO_Out,
  output logic        C_Out,
  output logic        InPort_Out,
  output logic        PC_In,
  output logic        MDR_In,
  output logic        MAR_In,
  output logic        IR_In,
  output logic        Y_In,
  output logic        ZHI_In,
  output logic        ZLO_In,
  output logic        HI_In,
  output logic        LO_In,
  output logic        OutPort_In,
  output logic        ConFF_In,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        G_RA,
  output logic        G_RB,
  output logic        G_RC,
  output logic        R_In,
  output logic        R_Out,
  output logic        BA_Out
);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_ALU, C_IMM, C_MD, C_NN, C_LD,
    C_LDI, C_ST, C_BR, C_JR, C_IN,
    C_OUT, C_MFHI, C_MFLO, C_HALT, C_NOP
  } cls_t;

  localparam logic [4:0] OP_ADD = 5'b00011;

  state_t     state, state_n, last_st;
  cls_t       cls;
  logic [4:0] opc;
  logic       unused_ir;

  assign opc       = IR[31:27];
  assign unused_ir = ^IR[26:0];

  // Instruction class from the opcode field.
  always_comb begin
    cls = C_NOP;
    case (opc) inside
      [5'd3:5'd11]:  cls = C_ALU;
      [5'd12:5'd14]: cls = C_IMM;
      5'd15, 5'd16:  cls = C_MD;
      5'd17, 5'd18:  cls = C_NN;
      5'd0:          cls = C_LD;
      5'd1:          cls = C_LDI;
      5'd2:          cls = C_ST;
      5'd19:         cls = C_BR;
      5'd20:         cls = C_JR;
      5'd22:         cls = C_IN;
      5'd23:         cls = C_OUT;
      5'd24:         cls = C_MFHI;
      5'd25:         cls = C_MFLO;
      5'd27:         cls = C_HALT;
      default:       cls = C_NOP;
    endcase
  end

  // Final execute step of each instruction class.
  always_comb begin
    last_st = S_T3;
    case (cls)
      C_ALU, C_IMM, C_LDI: last_st = S_T5;
      C_MD, C_BR:          last_st = S_T6;
      C_NN:                last_st = S_T4;
      C_LD, C_ST:          last_st = S_T7;
      default:             last_st = S_T3;
    endcase
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) state <= S_RESET;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_RESET: state_n = S_T0;
      S_T0:    state_n = S_T1;
      S_T1:    state_n = S_T2;
      S_T2:    state_n = S_T3;
      S_HALT:  state_n = S_HALT;
      default: begin
        // T7 is always terminal so a stray IR change cannot run past it.
        if (state == S_T3 && cls == C_HALT)
          state_n = S_HALT;
        else if (state == last_st || state == S_T7)
          state_n = Stop ? S_HALT : S_T0;
        else
          state_n = state_t'(state + 4'd1);
      end
    endcase
  end

  always_comb begin
    Run        = 1'b0;
    CONTROL    = 5'd0;
    PC_Out     = 1'b0;
    MDR_Out    = 1'b0;
    ZHI_Out    = 1'b0;
    ZLO_Out    = 1'b0;
    HI_Out     = 1'b0;
    LO_Out     = 1'b0;
    C_Out      = 1'b0;
    InPort_Out = 1'b0;
    PC_In      = 1'b0;
    MDR_In     = 1'b0;
    MAR_In     = 1'b0;
    IR_In      = 1'b0;
    Y_In       = 1'b0;
    ZHI_In     = 1'b0;
    ZLO_In     = 1'b0;
    HI_In      = 1'b0;
    LO_In      = 1'b0;
    OutPort_In = 1'b0;
    ConFF_In   = 1'b0;
    IncPC      = 1'b0;
    Read       = 1'b0;
    Write      = 1'b0;
    G_RA       = 1'b0;
    G_RB       = 1'b0;
    G_RC       = 1'b0;
    R_In       = 1'b0;
    R_Out      = 1'b0;
    BA_Out     = 1'b0;

    Run = (state != S_RESET) && (state != S_HALT);

    unique case (state)
      S_T0: begin
        PC_Out = 1'b1;
        MAR_In = 1'b1;
        IncPC  = 1'b1;
      end
      S_T1: begin
        Read   = 1'b1;
        MDR_In = 1'b1;
      end
      S_T2: begin
        MDR_Out = 1'b1;
        IR_In   = 1'b1;
      end
      S_T3: begin
        case (cls)
          C_ALU, C_IMM: begin
            G_RB  = 1'b1;
            R_Out = 1'b1;
            Y_In  = 1'b1;
          end
          C_MD: begin
            G_RA  = 1'b1;
            R_Out = 1'b1;
            Y_In  = 1'b1;
          end
          C_NN: begin
            G_RB    = 1'b1;
            R_Out   = 1'b1;
            CONTROL = opc;
            ZLO_In  = 1'b1;
          end
          C_LD, C_LDI, C_ST: begin
            G_RB   = 1'b1;
            BA_Out = 1'b1;
            Y_In   = 1'b1;
          end
          C_BR: begin
            G_RA     = 1'b1;
            R_Out    = 1'b1;
            ConFF_In = 1'b1;
          end
          C_JR: begin
            G_RA  = 1'b1;
            R_Out = 1'b1;
            PC_In = 1'b1;
          end
          C_IN: begin
            InPort_Out = 1'b1;
            G_RA       = 1'b1;
            R_In       = 1'b1;
          end
          C_OUT: begin
            G_RA       = 1'b1;
            R_Out      = 1'b1;
            OutPort_In = 1'b1;
          end
          C_MFHI: begin
            HI_Out = 1'b1;
            G_RA   = 1'b1;
            R_In   = 1'b1;
          end
          C_MFLO: begin
            LO_Out = 1'b1;
            G_RA   = 1'b1;
            R_In   = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        case (cls)
          C_ALU: begin
            G_RC    = 1'b1;
            R_Out   = 1'b1;
            CONTROL = opc;
            ZLO_In  = 1'b1;
          end
          C_IMM: begin
            C_Out   = 1'b1;
            CONTROL = opc;
            ZLO_In  = 1'b1;
          end
          C_MD: begin
            G_RB    = 1'b1;
            R_Out   = 1'b1;
            CONTROL = opc;
            ZHI_In  = 1'b1;
            ZLO_In  = 1'b1;
          end
          C_NN: begin
            ZLO_Out = 1'b1;
            G_RA    = 1'b1;
            R_In    = 1'b1;
          end
          C_LD, C_LDI, C_ST: begin
            C_Out   = 1'b1;
            CONTROL = OP_ADD;
            ZLO_In  = 1'b1;
          end
          C_BR: begin
            PC_Out = 1'b1;
            Y_In   = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        case (cls)
          C_ALU, C_IMM, C_LDI: begin
            ZLO_Out = 1'b1;
            G_RA    = 1'b1;
            R_In    = 1'b1;
          end
          C_MD: begin
            ZLO_Out = 1'b1;
            LO_In   = 1'b1;
          end
          C_LD, C_ST: begin
            ZLO_Out = 1'b1;
            MAR_In  = 1'b1;
          end
          C_BR: begin
            C_Out   = 1'b1;
            CONTROL = OP_ADD;
            ZLO_In  = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        case (cls)
          C_MD: begin
            ZHI_Out = 1'b1;
            HI_In   = 1'b1;
          end
          C_LD: begin
            Read   = 1'b1;
            MDR_In = 1'b1;
          end
          C_ST: begin
            G_RA   = 1'b1;
            R_Out  = 1'b1;
            MDR_In = 1'b1;
          end
          C_BR: begin
            // ConFF_Out is the registered result latched in T3.
            ZLO_Out = ConFF_Out;
            PC_In   = ConFF_Out;
          end
          default: ;
        endcase
      end
      S_T7: begin
        case (cls)
          C_LD: begin
            MDR_Out = 1'b1;
            G_RA    = 1'b1;
            R_In    = 1'b1;
          end
          C_ST: Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed table-driven check of the control_unit sequencer.
// Per-state expected strobe vectors, plus Clear/halt corner sequences.
module tb_control_unit;

  logic        Clock, Clear, ConFF_Out, Stop;
  logic [31:0] IR;
  logic        Run;
  logic [4:0]  CONTROL;
  logic PC_Out, MDR_Out, ZHI_Out, ZLO_Out, HI_Out, LO_Out, C_Out, InPort_Out;
  logic PC_In, MDR_In, MAR_In, IR_In, Y_In, ZHI_In, ZLO_In, HI_In, LO_In;
  logic OutPort_In, ConFF_In, IncPC, Read, Write;
  logic G_RA, G_RB, G_RC, R_In, R_Out, BA_Out;

  control_unit dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .ConFF_Out(ConFF_Out),
    .Stop(Stop), .Run(Run), .CONTROL(CONTROL),
    .PC_Out(PC_Out), .MDR_Out(MDR_Out), .ZHI_Out(ZHI_Out),
    .ZLO_Out(ZLO_Out), .HI_Out(HI_Out), .LO_Out(LO_Out),
    .C_Out(C_Out), .InPort_Out(InPort_Out),
    .PC_In(PC_In), .MDR_In(MDR_In), .MAR_In(MAR_In), .IR_In(IR_In),
    .Y_In(Y_In), .ZHI_In(ZHI_In), .ZLO_In(ZLO_In), .HI_In(HI_In),
    .LO_In(LO_In), .OutPort_In(OutPort_In), .ConFF_In(ConFF_In),
    .IncPC(IncPC), .Read(Read), .Write(Write),
    .G_RA(G_RA), .G_RB(G_RB), .G_RC(G_RC),
    .R_In(R_In), .R_Out(R_Out), .BA_Out(BA_Out)
  );

  logic [33:0] act;
  assign act = {Run, CONTROL,
                PC_Out, MDR_Out, ZHI_Out, ZLO_Out,
                HI_Out, LO_Out, C_Out, InPort_Out,
                PC_In, MDR_In, MAR_In, IR_In, Y_In,
                ZHI_In, ZLO_In, HI_In, LO_In,
                OutPort_In, ConFF_In, IncPC, Read, Write,
                G_RA, G_RB, G_RC, R_In, R_Out, BA_Out};

  localparam logic [33:0] RUN    = 34'd1 << 33;
  localparam logic [33:0] M_PCO  = 34'd1 << 27;
  localparam logic [33:0] M_MDRO = 34'd1 << 26;
  localparam logic [33:0] M_ZHIO = 34'd1 << 25;
  localparam logic [33:0] M_ZLOO = 34'd1 << 24;
  localparam logic [33:0] M_HIO  = 34'd1 << 23;
  localparam logic [33:0] M_LOO  = 34'd1 << 22;
  localparam logic [33:0] M_CO   = 34'd1 << 21;
  localparam logic [33:0] M_INO  = 34'd1 << 20;
  localparam logic [33:0] M_PCI  = 34'd1 << 19;
  localparam logic [33:0] M_MDRI = 34'd1 << 18;
  localparam logic [33:0] M_MARI = 34'd1 << 17;
  localparam logic [33:0] M_IRI  = 34'd1 << 16;
  localparam logic [33:0] M_YI   = 34'd1 << 15;
  localparam logic [33:0] M_ZHII = 34'd1 << 14;
  localparam logic [33:0] M_ZLOI = 34'd1 << 13;
  localparam logic [33:0] M_HII  = 34'd1 << 12;
  localparam logic [33:0] M_LOI  = 34'd1 << 11;
  localparam logic [33:0] M_OUTI = 34'd1 << 10;
  localparam logic [33:0] M_CFI  = 34'd1 << 9;
  localparam logic [33:0] M_INC  = 34'd1 << 8;
  localparam logic [33:0] M_RD   = 34'd1 << 7;
  localparam logic [33:0] M_WR   = 34'd1 << 6;
  localparam logic [33:0] M_GA   = 34'd1 << 5;
  localparam logic [33:0] M_GB   = 34'd1 << 4;
  localparam logic [33:0] M_GC   = 34'd1 << 3;
  localparam logic [33:0] M_RI   = 34'd1 << 2;
  localparam logic [33:0] M_RO   = 34'd1 << 1;
  localparam logic [33:0] M_BA   = 34'd1 << 0;

  localparam logic [33:0] F0 = RUN | M_PCO | M_MARI | M_INC;
  localparam logic [33:0] F1 = RUN | M_RD | M_MDRI;
  localparam logic [33:0] F2 = RUN | M_MDRO | M_IRI;
  localparam logic [33:0] WB = RUN | M_ZLOO | M_GA | M_RI;
  localparam logic [33:0] LD3 = RUN | M_GB | M_BA | M_YI;
  localparam logic [33:0] LD5 = RUN | M_ZLOO | M_MARI;

  typedef struct {
    logic [31:0] ir;
    logic        cf;
    logic        st;
    logic [33:0] exp;
    string       nm;
  } vec_t;

  vec_t vec[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [33:0] cw(input logic [4:0] c);
    return {1'b0, c, 28'd0};
  endfunction

  function automatic logic [31:0] op(input logic [4:0] o);
    return {o, 27'd0};
  endfunction

  task automatic v(input logic [31:0] ir, input logic cf,
                   input logic st, input logic [33:0] e,
                   input string nm);
    vec.push_back('{ir, cf, st, e, nm});
  endtask

  task automatic fetch(input logic [31:0] ir, input logic cf,
                       input string nm);
    v(ir, cf, 1'b0, F0, {nm, "_t0"});
    v(ir, cf, 1'b0, F1, {nm, "_t1"});
    v(ir, cf, 1'b0, F2, {nm, "_t2"});
  endtask

  task automatic check(input string nm, input logic [33:0] e);
    n_chk++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, e);
    end
    n_chk++;
    if ($countones(act[27:20]) > 1 || (act[7] && act[6])) begin
      n_fail++;
      $display("FAIL %s_excl: got %h want one bus source, no rd+wr",
               nm, act);
    end
  endtask

  task automatic step(input logic [33:0] e, input string nm);
    @(posedge Clock);
    #1;
    check(nm, e);
  endtask

  logic [31:0] ADD;

  initial begin
    Clear = 1'b1;
    IR = 32'd0;
    ConFF_Out = 1'b0;
    Stop = 1'b0;
    ADD = 32'h1988_0000;

    fetch(ADD, 1'b0, "add");
    v(ADD, 0, 0, RUN | M_GB | M_RO | M_YI, "add_t3");
    v(ADD, 0, 0, RUN | M_GC | M_RO | cw(5'd3) | M_ZLOI, "add_t4");
    v(ADD, 0, 0, WB, "add_t5");
    fetch(op(5'd11), 1'b0, "alu11");
    v(op(5'd11), 0, 0, RUN | M_GB | M_RO | M_YI, "alu11_t3");
    v(op(5'd11), 0, 0, RUN | M_GC | M_RO | cw(5'd11) | M_ZLOI, "alu11_t4");
    v(op(5'd11), 0, 0, WB, "alu11_t5");
    fetch(op(5'd12), 1'b0, "imm12");
    v(op(5'd12), 0, 0, RUN | M_GB | M_RO | M_YI, "imm12_t3");
    v(op(5'd12), 0, 0, RUN | M_CO | cw(5'd12) | M_ZLOI, "imm12_t4");
    v(op(5'd12), 0, 0, WB, "imm12_t5");
    fetch(op(5'd14), 1'b0, "imm14");
    v(op(5'd14), 0, 0, RUN | M_GB | M_RO | M_YI, "imm14_t3");
    v(op(5'd14), 0, 0, RUN | M_CO | cw(5'd14) | M_ZLOI, "imm14_t4");
    v(op(5'd14), 0, 0, WB, "imm14_t5");
    fetch(op(5'd15), 1'b0, "mul");
    v(op(5'd15), 0, 0, RUN | M_GA | M_RO | M_YI, "mul_t3");
    v(op(5'd15), 0, 1, RUN | M_GB | M_RO | cw(5'd15) | M_ZHII | M_ZLOI,
      "mul_t4");
    v(op(5'd15), 0, 0, RUN | M_ZLOO | M_LOI, "mul_t5");
    v(op(5'd15), 0, 0, RUN | M_ZHIO | M_HII, "mul_t6");
    fetch(op(5'd16), 1'b0, "div");
    v(op(5'd16), 0, 0, RUN | M_GA | M_RO | M_YI, "div_t3");
    v(op(5'd16), 0, 0, RUN | M_GB | M_RO | cw(5'd16) | M_ZHII | M_ZLOI,
      "div_t4");
    v(op(5'd16), 0, 0, RUN | M_ZLOO | M_LOI, "div_t5");
    v(op(5'd16), 0, 0, RUN | M_ZHIO | M_HII, "div_t6");
    fetch(op(5'd17), 1'b0, "neg");
    v(op(5'd17), 0, 0, RUN | M_GB | M_RO | cw(5'd17) | M_ZLOI, "neg_t3");
    v(op(5'd17), 0, 0, WB, "neg_t4");
    fetch(op(5'd18), 1'b0, "not");
    v(op(5'd18), 0, 0, RUN | M_GB | M_RO | cw(5'd18) | M_ZLOI, "not_t3");
    v(op(5'd18), 0, 0, WB, "not_t4");
    fetch(op(5'd0), 1'b0, "ld");
    v(op(5'd0), 0, 0, LD3, "ld_t3");
    v(op(5'd0), 0, 0, RUN | M_CO | cw(5'd3) | M_ZLOI, "ld_t4");
    v(op(5'd0), 0, 0, LD5, "ld_t5");
    v(op(5'd0), 0, 0, RUN | M_RD | M_MDRI, "ld_t6");
    v(op(5'd0), 0, 0, RUN | M_MDRO | M_GA | M_RI, "ld_t7");
    fetch(op(5'd1), 1'b0, "ldi");
    v(op(5'd1), 0, 0, LD3, "ldi_t3");
    v(op(5'd1), 0, 0, RUN | M_CO | cw(5'd3) | M_ZLOI, "ldi_t4");
    v(op(5'd1), 0, 0, WB, "ldi_t5");
    fetch(op(5'd2), 1'b0, "st");
    v(op(5'd2), 0, 0, LD3, "st_t3");
    v(op(5'd2), 0, 0, RUN | M_CO | cw(5'd3) | M_ZLOI, "st_t4");
    v(op(5'd2), 0, 0, LD5, "st_t5");
    v(op(5'd2), 0, 0, RUN | M_GA | M_RO | M_MDRI, "st_t6");
    v(op(5'd2), 0, 0, RUN | M_WR, "st_t7");
    fetch(op(5'd19), 1'b1, "br1");
    v(op(5'd19), 1, 0, RUN | M_GA | M_RO | M_CFI, "br1_t3");
    v(op(5'd19), 1, 0, RUN | M_PCO | M_YI, "br1_t4");
    v(op(5'd19), 1, 0, RUN | M_CO | cw(5'd3) | M_ZLOI, "br1_t5");
    v(op(5'd19), 1, 0, RUN | M_ZLOO | M_PCI, "br1_t6");
    fetch(op(5'd19), 1'b0, "br0");
    v(op(5'd19), 0, 0, RUN | M_GA | M_RO | M_CFI, "br0_t3");
    v(op(5'd19), 0, 0, RUN | M_PCO | M_YI, "br0_t4");
    v(op(5'd19), 0, 0, RUN | M_CO | cw(5'd3) | M_ZLOI, "br0_t5");
    v(op(5'd19), 0, 0, RUN, "br0_t6");
    fetch(op(5'd20), 1'b0, "jr");
    v(op(5'd20), 0, 0, RUN | M_GA | M_RO | M_PCI, "jr_t3");
    fetch(op(5'd21), 1'b0, "jal");
    v(op(5'd21), 0, 0, RUN, "jal_t3");
    fetch(op(5'd22), 1'b0, "in");
    v(op(5'd22), 0, 0, RUN | M_INO | M_GA | M_RI, "in_t3");
    fetch(op(5'd23), 1'b0, "out");
    v(op(5'd23), 0, 0, RUN | M_GA | M_RO | M_OUTI, "out_t3");
    fetch(op(5'd24), 1'b0, "mfhi");
    v(op(5'd24), 0, 0, RUN | M_HIO | M_GA | M_RI, "mfhi_t3");
    fetch(op(5'd25), 1'b0, "mflo");
    v(op(5'd25), 0, 0, RUN | M_LOO | M_GA | M_RI, "mflo_t3");
    fetch(op(5'd26), 1'b0, "nop");
    v(op(5'd26), 0, 0, RUN, "nop_t3");
    fetch(op(5'd31), 1'b0, "undef");
    v(op(5'd31), 0, 0, RUN, "undef_t3");
    fetch(ADD, 1'b0, "adds");
    v(ADD, 0, 0, RUN | M_GB | M_RO | M_YI, "adds_t3");
    v(ADD, 0, 0, RUN | M_GC | M_RO | cw(5'd3) | M_ZLOI, "adds_t4");
    v(ADD, 0, 1, WB, "adds_t5");
    for (int i = 0; i < 4; i++) v(ADD, 0, 0, 34'd0, "adds_halt");

    // Reset held across edges.
    repeat (2) @(posedge Clock);
    #1;
    check("reset_hold", 34'd0);
    @(negedge Clock);
    Clear = 1'b0;

    for (int i = 0; i < vec.size(); i++) begin
      @(posedge Clock);
      #1;
      IR = vec[i].ir;
      ConFF_Out = vec[i].cf;
      Stop = vec[i].st;
      #1;
      check(vec[i].nm, vec[i].exp);
    end

    // Clear out of HALT, then a halt instruction.
    @(negedge Clock);
    Clear = 1'b1;
    IR = op(5'd27);
    Stop = 1'b0;
    ConFF_Out = 1'b0;
    #1;
    check("clr_halt", 34'd0);
    @(negedge Clock);
    Clear = 1'b0;
    step(F0, "hlt_t0");
    step(F1, "hlt_t1");
    step(F2, "hlt_t2");
    step(RUN, "hlt_t3");
    for (int i = 0; i < 12; i++) step(34'd0, "hlt_hold");

    // Clear between edges during ld T6.
    @(negedge Clock);
    Clear = 1'b1;
    IR = op(5'd0);
    #1;
    check("clr_async", 34'd0);
    @(negedge Clock);
    Clear = 1'b0;
    step(F0, "ldc_t0");
    step(F1, "ldc_t1");
    step(F2, "ldc_t2");
    step(LD3, "ldc_t3");
    step(RUN | M_CO | cw(5'd3) | M_ZLOI, "ldc_t4");
    step(LD5, "ldc_t5");
    step(RUN | M_RD | M_MDRI, "ldc_t6");
    @(negedge Clock);
    Clear = 1'b1;
    #1;
    check("clr_mid_t6", 34'd0);
    step(34'd0, "clr_edge");
    @(negedge Clock);
    Clear = 1'b0;
    step(F0, "rst_t0");
    step(F1, "rst_t1");
    step(F2, "rst_t2");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
